// File: rtl/hilo_muldiv.sv
// HI/LO unit: iterative signed/unsigned shift-add multiplier and restoring divider
// writing a 2*WIDTH-bit result into HI/LO, plus single-cycle MTHI/MTLO writes.
module hilo_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic [1:0]       stateDbg
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } stateT;

   stateT            state, nextState;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] accHi, accLo, operand;
   logic             isDiv, negRes, negRem, divZero;

   // Handshake: start is a request taken only on an edge where busy=0; while
   // busy=1 every start (any op) is dropped and the issuer must hold/stall.
   logic accept, mulDivStart, mthiStart, mtloStart;
   assign accept      = (state == IDLE) && start;
   assign mulDivStart = accept && !op[2];
   assign mthiStart   = accept && (op == 3'd4);
   assign mtloStart   = accept && (op == 3'd5);

   // Signed ops are 0 (MULT) and 2 (DIV); the datapath works on magnitudes.
   logic             signedOp, signA, signB;
   logic [WIDTH-1:0] magA, magB;
   assign signedOp = !op[0];
   assign signA    = signedOp && src_a[WIDTH-1];
   assign signB    = signedOp && src_b[WIDTH-1];
   assign magA     = signA ? -src_a : src_a;
   assign magB     = signB ? -src_b : src_b;

   // One shift-add step: {accHi,accLo} is the product with the multiplier
   // draining out of accLo's low end.
   logic [WIDTH:0] mulSum;
   assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);

   // One restoring step: accHi is the remainder, accLo shifts the dividend
   // out of its top and the quotient bits in at the bottom.
   logic [WIDTH:0]   divShift;
   logic             divFits;
   logic [WIDTH-1:0] divRem;
   assign divShift = {accHi, accLo[WIDTH-1]};
   assign divFits  = divShift >= {1'b0, operand};
   assign divRem   = divShift[WIDTH-1:0] - operand;

   logic [2*WIDTH-1:0] product, fixProd;
   logic [WIDTH-1:0]   fixQuo, fixRem;
   assign product = {accHi, accLo};
   assign fixProd = negRes ? -product : product;
   assign fixQuo  = negRes ? -accLo : accLo;
   assign fixRem  = negRem ? -accHi : accHi;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (mulDivStart) nextState = CALC;
         CALC:    if (count == CW'(1)) nextState = FIX;
         FIX:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         accHi   <= '0;
         accLo   <= '0;
         operand <= '0;
         isDiv   <= 1'b0;
         negRes  <= 1'b0;
         negRem  <= 1'b0;
         divZero <= 1'b0;
         hi_out  <= '0;
         lo_out  <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (mulDivStart) begin
                  isDiv   <= op[1];
                  operand <= op[1] ? magB : magA;
                  accLo   <= op[1] ? magA : magB;
                  accHi   <= '0;
                  count   <= CW'(WIDTH);
                  negRes  <= signA ^ signB;
                  negRem  <= signA;
                  divZero <= op[1] && (src_b == '0);
               end else if (mthiStart) begin
                  hi_out <= src_a;
               end else if (mtloStart) begin
                  lo_out <= src_a;
               end
            end
            CALC: begin
               count <= count - CW'(1);
               if (isDiv) begin
                  accHi <= divFits ? divRem : divShift[WIDTH-1:0];
                  accLo <= {accLo[WIDTH-2:0], divFits};
               end else begin
                  accHi <= mulSum[WIDTH:1];
                  accLo <= {mulSum[0], accLo[WIDTH-1:1]};
               end
            end
            FIX: begin
               done <= 1'b1;
               if (isDiv) begin
                  // A zero divisor leaves the dividend as remainder, so HI is src_a.
                  hi_out <= fixRem;
                  lo_out <= divZero ? '1 : fixQuo;
               end else begin
                  {hi_out, lo_out} <= fixProd;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign stateDbg = state;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv at WIDTH=32 and WIDTH=8: directed and random ops checked
// against an arithmetic model, plus handshake, ignore-while-busy and reset cases.
module tb_hilo_muldiv;

   logic        clk = 1'b0;
   logic        reset;
   logic        start32, start8;
   logic [2:0]  op32, op8;
   logic [31:0] a32, b32;
   logic [7:0]  a8, b8;
   logic        busy32, done32, busy8, done8;
   logic [31:0] hi32, lo32;
   logic [7:0]  hi8, lo8;
   logic [1:0]  st32, st8;

   int compared = 0;
   int mismatched = 0;
   logic [63:0] exp_q[$];
   logic [31:0] expHi[2];
   logic [31:0] expLo[2];

   always #5 clk = ~clk;

   hilo_muldiv #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start(start32), .op(op32), .src_a(a32), .src_b(b32),
      .busy(busy32), .done(done32), .hi_out(hi32), .lo_out(lo32), .stateDbg(st32));

   hilo_muldiv #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
      .busy(busy8), .done(done8), .hi_out(hi8), .lo_out(lo8), .stateDbg(st8));

   function automatic logic gBusy(input bit w8);
      return w8 ? busy8 : busy32;
   endfunction
   function automatic logic gDone(input bit w8);
      return w8 ? done8 : done32;
   endfunction
   function automatic logic [31:0] gHi(input bit w8);
      return w8 ? {24'd0, hi8} : hi32;
   endfunction
   function automatic logic [31:0] gLo(input bit w8);
      return w8 ? {24'd0, lo8} : lo32;
   endfunction

   // Reference: plain integer arithmetic on sign/zero-extended operands.
   function automatic logic [63:0] model(input bit w8, input logic [2:0] o,
                                         input logic [31:0] a, input logic [31:0] b);
      int w;
      longint mask, ua, ub, sa, sb, p, q, r;
      logic [31:0] hi, lo;
      w    = w8 ? 8 : 32;
      mask = (longint'(1) << w) - 1;
      ua   = longint'({32'd0, a}) & mask;
      ub   = longint'({32'd0, b}) & mask;
      sa   = (((ua >> (w - 1)) & 1) != 0) ? ua - (longint'(1) << w) : ua;
      sb   = (((ub >> (w - 1)) & 1) != 0) ? ub - (longint'(1) << w) : ub;
      hi   = '0;
      lo   = '0;
      case (o)
         3'd0, 3'd1: begin
            p  = (o == 3'd0) ? sa * sb : ua * ub;
            hi = 32'((p >> w) & mask);
            lo = 32'(p & mask);
         end
         3'd2, 3'd3: begin
            if (ub == 0) begin
               hi = 32'(ua);
               lo = 32'(mask);
            end else begin
               q  = (o == 3'd2) ? sa / sb : ua / ub;
               r  = (o == 3'd2) ? sa % sb : ua % ub;
               hi = 32'(r & mask);
               lo = 32'(q & mask);
            end
         end
         default: ;
      endcase
      return {hi, lo};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic drive(input bit w8, input bit s, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b);
      if (w8) begin
         start8 = s; op8 = o; a8 = a[7:0]; b8 = b[7:0];
      end else begin
         start32 = s; op32 = o; a32 = a; b32 = b;
      end
   endtask

   // Called at a negedge; issues at once, returns at the negedge of the done cycle.
   task automatic runOp(input bit w8, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb, input string tag);
      int w, k, busyCnt, heldBad;
      bit seen;
      logic [31:0] holdHi, holdLo;
      logic [63:0] e;
      w = w8 ? 8 : 32;
      exp_q.push_back(model(w8, o, a, b));
      holdHi = expHi[w8];
      holdLo = expLo[w8];
      drive(w8, 1'b1, o, a, b);
      @(posedge clk);
      #1 drive(w8, 1'b0, 3'd0, 32'd0, 32'd0);
      k = 0; busyCnt = 0; heldBad = 0; seen = 0;
      while (!seen && k < 3 * w + 10) begin
         @(negedge clk);
         k++;
         if (disturb && k == 5) drive(w8, 1'b1, 3'd5, $urandom, 32'd0);
         if (disturb && k == 6) drive(w8, 1'b1, 3'd0, $urandom, $urandom);
         if (disturb && k == 7) drive(w8, 1'b0, 3'd0, 32'd0, 32'd0);
         if (gDone(w8)) seen = 1;
         else begin
            if (gBusy(w8)) busyCnt++;
            if (gHi(w8) !== holdHi || gLo(w8) !== holdLo) heldBad++;
         end
      end
      e = exp_q.pop_front();
      chk({tag, " done"}, 64'(seen), 64'd1);
      chk({tag, " latency"}, 64'(k), 64'(w + 2));
      chk({tag, " busy_cycles"}, 64'(busyCnt), 64'(w + 1));
      chk({tag, " hilo_held"}, 64'(heldBad), 64'd0);
      chk({tag, " busy_at_done"}, 64'(gBusy(w8)), 64'd0);
      chk({tag, " hi"}, 64'(gHi(w8)), 64'(e[63:32]));
      chk({tag, " lo"}, 64'(gLo(w8)), 64'(e[31:0]));
      expHi[w8] = e[63:32];
      expLo[w8] = e[31:0];
   endtask

   task automatic mtOp(input bit w8, input logic [2:0] o, input logic [31:0] a, input string tag);
      logic [31:0] m;
      m = w8 ? {24'd0, a[7:0]} : a;
      drive(w8, 1'b1, o, a, $urandom);
      @(posedge clk);
      #1 drive(w8, 1'b0, 3'd0, 32'd0, 32'd0);
      if (o == 3'd4) expHi[w8] = m;
      if (o == 3'd5) expLo[w8] = m;
      @(negedge clk);
      chk({tag, " hi"}, 64'(gHi(w8)), 64'(expHi[w8]));
      chk({tag, " lo"}, 64'(gLo(w8)), 64'(expLo[w8]));
      chk({tag, " busy"}, 64'(gBusy(w8)), 64'd0);
      chk({tag, " no_done"}, 64'(gDone(w8)), 64'd0);
   endtask

   function automatic logic [31:0] pick(input bit allowZero);
      case ($urandom_range(0, 6))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return allowZero ? 32'd0 : 32'd3;
         3: return 32'h0000_0080;
         default: return $urandom;
      endcase
   endfunction

   task automatic randomOps(input bit w8, input int n);
      for (int i = 0; i < n; i++) begin
         runOp(w8, 3'($urandom_range(0, 3)), pick(1'b0), pick(1'b1), 1'b0,
               w8 ? "rand8" : "rand32");
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int doneCnt;
      reset = 1'b1;
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      expHi = '{32'd0, 32'd0};
      expLo = '{32'd0, 32'd0};
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset hi32", 64'(hi32), 64'd0);
      chk("reset lo32", 64'(lo32), 64'd0);
      chk("reset busy32", 64'(busy32), 64'd0);
      chk("reset done32", 64'(done32), 64'd0);
      chk("reset hi8", 64'(hi8), 64'd0);
      chk("reset busy8", 64'(busy8), 64'd0);

      // WIDTH=32 directed vectors, issued back-to-back on each done cycle
      runOp(1'b0, 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg");
      chk("mult_neg const_hi", 64'(hi32), 64'hFFFF_FFFF);
      chk("mult_neg const_lo", 64'(lo32), 64'hFFFF_FFF1);
      runOp(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
      runOp(1'b0, 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
      chk("mult_minmin const_hi", 64'(hi32), 64'h4000_0000);
      runOp(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
      runOp(1'b0, 3'd3, 32'd7, 32'd2, 1'b0, "divu_7_2");
      runOp(1'b0, 3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
      chk("div_7_m2 const_lo", 64'(lo32), 64'hFFFF_FFFD);
      runOp(1'b0, 3'd3, 32'h1234, 32'd0, 1'b0, "divu_by0");
      runOp(1'b0, 3'd2, 32'hFFFF_FFFB, 32'd0, 1'b0, "div_neg_by0");
      runOp(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
      chk("div_ovf const_lo", 64'(lo32), 64'h8000_0000);

      repeat (2) @(negedge clk);
      mtOp(1'b0, 3'd4, 32'hA5A5_A5A5, "mthi");
      mtOp(1'b0, 3'd5, 32'h5A5A_0F0F, "mtlo");
      mtOp(1'b0, 3'd6, 32'h1111_1111, "noop6");
      mtOp(1'b0, 3'd7, 32'h2222_2222, "noop7");

      // MTLO and a second MULT arrive mid-operation and must be dropped
      runOp(1'b0, 3'd0, 32'h0001_2345, 32'hFFFF_0003, 1'b1, "busy_ignore");
      runOp(1'b0, 3'd3, 32'hDEAD_BEEF, 32'h0000_1000, 1'b0, "b2b_divu");

      randomOps(1'b0, 20);

      // Reset ten cycles into a DIVU abandons it
      @(negedge clk);
      drive(1'b0, 1'b1, 3'd3, 32'hCAFE_F00D, 32'd17);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      expHi = '{32'd0, 32'd0};
      expLo = '{32'd0, 32'd0};
      @(negedge clk);
      chk("rst_mid busy", 64'(busy32), 64'd0);
      chk("rst_mid hi", 64'(hi32), 64'd0);
      chk("rst_mid lo", 64'(lo32), 64'd0);
      doneCnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done32) doneCnt++;
         @(negedge clk);
      end
      chk("rst_mid no_done", 64'(doneCnt), 64'd0);

      // WIDTH=8 instance
      runOp(1'b1, 3'd0, 32'hFD, 32'h05, 1'b0, "w8_mult");
      chk("w8_mult const_hi", 64'(hi8), 64'hFF);
      chk("w8_mult const_lo", 64'(lo8), 64'hF1);
      runOp(1'b1, 3'd1, 32'hFF, 32'hFF, 1'b0, "w8_multu");
      runOp(1'b1, 3'd2, 32'hF9, 32'h02, 1'b0, "w8_div");
      runOp(1'b1, 3'd3, 32'h07, 32'h00, 1'b0, "w8_divu_by0");
      runOp(1'b1, 3'd2, 32'h80, 32'hFF, 1'b0, "w8_div_ovf");
      runOp(1'b1, 3'd2, 32'h07, 32'hFE, 1'b1, "w8_busy_ignore");
      mtOp(1'b1, 3'd4, 32'h3C, "w8_mthi");
      randomOps(1'b1, 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
